aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Sequencer for the AES key expansion datapath. Drives its round/step/clear/op/key_len inputs and the full-key register mux and write enable.
//  Delivers NR+1 round keys per block to the cipher core over a valid/ready handshake.
//  For decryption, first runs a forward pre-expansion to derive the decryption start key.
// PARAMETERS
//  AES192Enable  1  0: AES-192 key_len is rejected as invalid
// PORTS
//  clk_i         in   1  clock
//  rst_i         in   1  async active-high reset
//  start_i       in   1  request a key schedule run
//  start_ready_o out  1  high only in IDLE; run accepted when start_i & start_ready_o
//  op_i          in   1  CIPH_FWD=0 / CIPH_INV=1, sampled on accept
//  key_len_i     in   3  one-hot AES_128/192/256, sampled on accept
//  abort_i       in   1  abandon run and wipe key
//  key_new_i     in   1  key register reloaded by software (cache invalidate)
//  rk_valid_o    out  1  round key on key expand output valid
//  rk_ready_i    in   1  cipher core consumes round key
//  rk_last_o     out  1  qualifies final round key (index NR)
//  step_o        out  1  to key expand step_i
//  clear_o       out  1  to key expand clear_i (rcon reinit)
//  round_o       out  4  to key expand round_i
//  op_o          out  1  to key expand op_i
//  key_len_o     out  3  to key expand key_len_i (latched copy)
//  key_sel_o     out  2  KEY_FULL_ENC_INIT/DEC_INIT/ROUND/CLEAR mux select
//  key_we_o      out  1  full-key register write enable
//  done_o        out  1  1-cycle pulse on last round-key transfer
//  err_o         out  1  1-cycle pulse: start with invalid key_len
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0 except start_ready_o=1, key_len_o=AES_128, key_sel_o=KEY_FULL_CLEAR.
//  NR = 10/12/14 for AES_128/192/256.
//  Invalid key_len (not one-hot, or AES_192 with AES192Enable=0) on start:
//   err_o=1 next cycle, stay IDLE, no datapath activity.
//  FSM:
//   IDLE     -> accept -> INIT.
//   INIT     1 cycle: clear_o=1, key_we_o=1, key_sel_o=ENC_INIT, op_o=FWD.
//            -> DEC_PREP if op INV, else ROUND.
//   DEC_PREP NR cycles: step_o=1, key_we_o=1, sel=ROUND, op_o=FWD, round_o=0..NR-1.
//            -> DEC_LOAD.
//   DEC_LOAD 1 cycle: clear_o=1, key_we_o=1, sel=DEC_INIT, op_o=INV.
//            -> ROUND.
//   ROUND    rk_valid_o=1; round_o = transfers done so far (0..NR); op_o = latched op.
//            Transfer k<NR: step_o=1, key_we_o=1, sel=ROUND, same cycle.
//            Transfer k=NR: rk_last_o=1, done_o=1, no step; -> IDLE.
//   WIPE     1 cycle: clear_o=1, key_we_o=1, sel=CLEAR -> IDLE.
//  rk_valid_o never drops without a transfer; round_o and key stay stable while stalled.
//  step_o/key_we_o are never asserted without rk_ready_i in ROUND.
//  abort_i in any non-IDLE state has priority over all transitions and suppresses that cycle's transfer/step -> WIPE.
//  abort_i in IDLE also -> WIPE.
//  start_i is ignored outside IDLE.
//  Counter wraps only via FSM exit; counter is 4 bits and never exceeds 14.
//  rst_i mid-run returns to IDLE immediately; the datapath rcon is re-initialised by the next INIT.
// CONFIGURATION
//  AES_KEY_SCHED_DEC_CACHE_EN defined:
//   - A dec_key_valid flag is set on DEC_LOAD and cleared by key_new_i, abort_i, reset, or a key_len change.
//   - An INV run with the flag set skips INIT and DEC_PREP: IDLE -> DEC_LOAD -> ROUND.
//   - key_sel_o=DEC_INIT then selects the cached decryption key held outside this block.
//  Undefined: every INV run performs DEC_PREP; key_new_i is ignored.
// STRUCTURE
//  aes_pkg: NR lookup function, key_len/ciph_op/key_full_sel enums, new aes_key_sched_e state enum.
//  One sub-module, aes_round_ctr: 4-bit counter with clear, increment, and terminal-compare against NR.
// TESTING
//  1. AES_128 FWD, rk_ready_i=1, start at cycle 0:
//     INIT@1; rk_valid_o@2..12; round_o 0..10; 10 steps; rk_last_o/done_o@12.
//  2. AES_256 INV:
//     DEC_PREP 14 cycles with op_o=0; DEC_LOAD with op_o=1; then 15 transfers; done after the 15th.
//  3. Backpressure: rk_ready_i toggles 0/1 pseudo-randomly.
//     No step_o without ready; round_o stable while stalled; still exactly NR steps.
//  4. start with key_len_i=3'b011 -> err_o pulse; start_ready_o stays 1; no clear_o/key_we_o.
//  5. abort_i at ROUND round_o=5 with rk_ready_i=1 -> no step that cycle; WIPE sel=CLEAR; IDLE after.
//  6. CACHE_EN: two AES_192 INV runs, no key_new_i.
//     Second run has no DEC_PREP (first key 2 cycles after accept).
//     After key_new_i, DEC_PREP returns.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key schedule sequencer: key length
// and cipher op encodings, full-key mux selects, sequencer states, NR lookup.
package aes_pkg;

   typedef enum logic [2:0] {
      AES_128 = 3'b001,
      AES_192 = 3'b010,
      AES_256 = 3'b100
   } key_len_e;

   typedef enum logic {
      CIPH_FWD = 1'b0,
      CIPH_INV = 1'b1
   } ciph_op_e;

   typedef enum logic [1:0] {
      KEY_FULL_ENC_INIT = 2'd0,
      KEY_FULL_DEC_INIT = 2'd1,
      KEY_FULL_ROUND    = 2'd2,
      KEY_FULL_CLEAR    = 2'd3
   } key_full_sel_e;

   typedef enum logic [2:0] {
      KS_IDLE,
      KS_INIT,
      KS_DEC_PREP,
      KS_DEC_LOAD,
      KS_ROUND,
      KS_WIPE
   } aes_key_sched_e;

   localparam int unsigned RoundCtrW = 4;

   function automatic logic [RoundCtrW-1:0] aes_nr(input logic [2:0] key_len);
      logic [RoundCtrW-1:0] nr;
      case (key_len)
         AES_192: nr = 4'd12;
         AES_256: nr = 4'd14;
         default: nr = 4'd10;
      endcase
      return nr;
   endfunction

   // AES-192 support can be fused off, in which case its encoding is illegal.
   function automatic logic key_len_valid(input logic [2:0] key_len, input logic en192);
      return $onehot(key_len) && (en192 || (key_len != AES_192));
   endfunction

endpackage

// File: rtl/aes_round_ctr.sv
// Round counter for the key schedule sequencer: clear, saturating increment,
// and terminal compares against NR and NR-1.
module aes_round_ctr
   import aes_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 inc_i,
   input  logic [RoundCtrW-1:0] nr_i,
   output logic [RoundCtrW-1:0] cnt_o,
   output logic                 tc_o,
   output logic                 tc_pre_o
);

   logic [RoundCtrW-1:0] cnt_q;

   // Saturate at NR so the count can never run past 14 even if inc is held.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != nr_i)) begin
         cnt_q <= cnt_q + RoundCtrW'(1);
      end
   end

   assign cnt_o    = cnt_q;
   assign tc_o     = (cnt_q == nr_i);
   assign tc_pre_o = (cnt_q == (nr_i - RoundCtrW'(1)));

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Key schedule sequencer: drives the key expand datapath and hands NR+1 round
// keys to the cipher core. Optional decryption-key cache: AES_KEY_SCHED_DEC_CACHE_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; key register holds cleared/cached content
// INIT     | load encryption start key, reinit rcon
// DEC_PREP | forward pre-expansion, NR steps, to reach the decryption key
// DEC_LOAD | load decryption start key, reinit rcon in inverse mode
// ROUND    | offer round keys 0..NR, one step per accepted transfer
// WIPE     | clear the full-key register after an abort
module aes_key_sched_ctrl
   import aes_pkg::*;
#(
   parameter bit AES192Enable = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   output logic       start_ready_o,
   input  logic       op_i,
   input  logic [2:0] key_len_i,
   input  logic       abort_i,
   input  logic       key_new_i,
   output logic       rk_valid_o,
   input  logic       rk_ready_i,
   output logic       rk_last_o,
   output logic       step_o,
   output logic       clear_o,
   output logic [3:0] round_o,
   output logic       op_o,
   output logic [2:0] key_len_o,
   output logic [1:0] key_sel_o,
   output logic       key_we_o,
   output logic       done_o,
   output logic       err_o
);

   aes_key_sched_e state_q, state_d;

   logic                 op_q;
   logic [2:0]           key_len_q;
   logic                 err_q;
   logic                 ctr_clr, ctr_inc, ctr_tc, ctr_tc_pre;
   logic [RoundCtrW-1:0] ctr, nr;
   logic                 start_acc, start_ok, dec_hit;

   assign nr        = aes_nr(key_len_q);
   assign start_acc = start_i & start_ready_o;
   assign start_ok  = start_acc & key_len_valid(key_len_i, AES192Enable);

   aes_round_ctr u_round_ctr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (ctr_clr),
      .inc_i    (ctr_inc),
      .nr_i     (nr),
      .cnt_o    (ctr),
      .tc_o     (ctr_tc),
      .tc_pre_o (ctr_tc_pre)
   );

`ifdef AES_KEY_SCHED_DEC_CACHE_EN
   logic dec_key_valid_q;

   // The cached key is only reusable for the same key length and key material.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dec_key_valid_q <= 1'b0;
      end else if (key_new_i || abort_i || (start_ok && (key_len_i != key_len_q))) begin
         dec_key_valid_q <= 1'b0;
      end else if (state_q == KS_DEC_LOAD) begin
         dec_key_valid_q <= 1'b1;
      end
   end

   assign dec_hit = dec_key_valid_q & ~key_new_i & (key_len_i == key_len_q) & op_i;
`else
   logic unused_key_new;
   assign unused_key_new = key_new_i;
   assign dec_hit        = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= KS_IDLE;
         op_q      <= CIPH_FWD;
         key_len_q <= AES_128;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= start_acc & ~start_ok;
         if (start_ok) begin
            op_q      <= op_i;
            key_len_q <= key_len_i;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      start_ready_o = 1'b0;
      rk_valid_o    = 1'b0;
      rk_last_o     = 1'b0;
      step_o        = 1'b0;
      clear_o       = 1'b0;
      round_o       = '0;
      op_o          = CIPH_FWD;
      key_sel_o     = KEY_FULL_CLEAR;
      key_we_o      = 1'b0;
      done_o        = 1'b0;
      ctr_clr       = 1'b0;
      ctr_inc       = 1'b0;

      unique case (state_q)
         KS_IDLE: begin
            start_ready_o = ~abort_i;
            ctr_clr       = 1'b1;
            if (abort_i) begin
               state_d = KS_WIPE;
            end else if (start_ok) begin
               state_d = dec_hit ? KS_DEC_LOAD : KS_INIT;
            end
         end
         KS_INIT: begin
            clear_o   = 1'b1;
            key_we_o  = 1'b1;
            key_sel_o = KEY_FULL_ENC_INIT;
            ctr_clr   = 1'b1;
            state_d   = op_q ? KS_DEC_PREP : KS_ROUND;
         end
         KS_DEC_PREP: begin
            step_o    = 1'b1;
            key_we_o  = 1'b1;
            key_sel_o = KEY_FULL_ROUND;
            round_o   = ctr;
            if (ctr_tc_pre) begin
               ctr_clr = 1'b1;
               state_d = KS_DEC_LOAD;
            end else begin
               ctr_inc = 1'b1;
            end
         end
         KS_DEC_LOAD: begin
            clear_o   = 1'b1;
            key_we_o  = 1'b1;
            key_sel_o = KEY_FULL_DEC_INIT;
            op_o      = CIPH_INV;
            ctr_clr   = 1'b1;
            state_d   = KS_ROUND;
         end
         KS_ROUND: begin
            rk_valid_o = 1'b1;
            rk_last_o  = ctr_tc;
            round_o    = ctr;
            op_o       = op_q;
            if (rk_ready_i) begin
               if (ctr_tc) begin
                  done_o  = 1'b1;
                  ctr_clr = 1'b1;
                  state_d = KS_IDLE;
               end else begin
                  step_o    = 1'b1;
                  key_we_o  = 1'b1;
                  key_sel_o = KEY_FULL_ROUND;
                  ctr_inc   = 1'b1;
               end
            end
         end
         KS_WIPE: begin
            clear_o   = 1'b1;
            key_we_o  = 1'b1;
            key_sel_o = KEY_FULL_CLEAR;
            ctr_clr   = 1'b1;
            state_d   = KS_IDLE;
         end
         default: begin
            state_d = KS_IDLE;
         end
      endcase

      // Abort wins over everything: no handshake, no datapath write this cycle.
      if (abort_i && (state_q != KS_IDLE)) begin
         if (state_q != KS_WIPE) begin
            rk_valid_o = 1'b0;
            rk_last_o  = 1'b0;
            step_o     = 1'b0;
            clear_o    = 1'b0;
            key_we_o   = 1'b0;
            key_sel_o  = KEY_FULL_CLEAR;
            done_o     = 1'b0;
         end
         ctr_inc = 1'b0;
         ctr_clr = 1'b1;
         state_d = KS_WIPE;
      end
   end

   assign key_len_o = key_len_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: phase-queue reference model,
// table-driven runs, randomized backpressure and hand-written corner sequences.
module tb_aes_key_sched_ctrl;

   localparam int PH_IDLE  = 0;
   localparam int PH_INIT  = 1;
   localparam int PH_PREP  = 2;
   localparam int PH_LOAD  = 3;
   localparam int PH_ROUND = 4;
   localparam int PH_WIPE  = 5;
   localparam int PH_ABORT = 6;

`ifdef AES_KEY_SCHED_DEC_CACHE_EN
   localparam bit CacheEn = 1'b1;
`else
   localparam bit CacheEn = 1'b0;
`endif

   typedef struct {
      logic       op;
      logic [2:0] kl;
      int         pct;
      int         abort_k;
      int         exp_steps;
      int         exp_done;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic       op_i = 1'b0;
   logic [2:0] key_len_i = 3'b001;
   logic       abort_i = 1'b0;
   logic       key_new_i = 1'b0;
   logic       rk_ready_i = 1'b0;
   logic       start_ready_o, rk_valid_o, rk_last_o, step_o, clear_o, op_o;
   logic       key_we_o, done_o, err_o;
   logic [3:0] round_o;
   logic [2:0] key_len_o;
   logic [1:0] key_sel_o;

   int         n_chk = 0;
   int         n_fail = 0;
   logic [2:0] kl_model = 3'b001;
   bit         dec_cached = 1'b0;
   logic [17:0] act;

   assign act = {err_o, start_ready_o, rk_valid_o, rk_last_o, step_o, clear_o,
                 round_o, op_o, key_sel_o, key_we_o, done_o, key_len_o};

   aes_key_sched_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_ready_o(start_ready_o),
      .op_i(op_i), .key_len_i(key_len_i), .abort_i(abort_i), .key_new_i(key_new_i),
      .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i), .rk_last_o(rk_last_o),
      .step_o(step_o), .clear_o(clear_o), .round_o(round_o), .op_o(op_o),
      .key_len_o(key_len_o), .key_sel_o(key_sel_o), .key_we_o(key_we_o),
      .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int nr_of(input logic [2:0] kl);
      if (kl == 3'b010) return 12;
      if (kl == 3'b100) return 14;
      return 10;
   endfunction

   // Expected outputs for one cycle of a given phase; mask hides unspecified fields.
   function automatic void model(input int kind, input int k, input bit rdy, input bit op,
                                 input int nr, input bit err, input logic [2:0] kl,
                                 output logic [17:0] e, output logic [17:0] m);
      logic srdy, vld, last, stp, clr, opo, we, dn;
      logic [3:0] rnd;
      logic [1:0] sel;
      bit m_sel, m_rnd, m_op;
      srdy = 0; vld = 0; last = 0; stp = 0; clr = 0; opo = 0; we = 0; dn = 0;
      rnd = '0; sel = 2'd3; m_sel = 1; m_rnd = 1; m_op = 1;
      case (kind)
         PH_IDLE:  srdy = 1;
         PH_INIT:  begin clr = 1; we = 1; sel = 2'd0; m_rnd = 0; end
         PH_PREP:  begin stp = 1; we = 1; sel = 2'd2; rnd = 4'(k); end
         PH_LOAD:  begin clr = 1; we = 1; sel = 2'd1; opo = 1; m_rnd = 0; end
         PH_ROUND: begin
            vld = 1; rnd = 4'(k); opo = op; last = (k == nr);
            if (rdy && (k < nr)) begin stp = 1; we = 1; sel = 2'd2; end
            else begin
               m_sel = 0;
               if (rdy) dn = 1;
            end
         end
         PH_WIPE:  begin clr = 1; we = 1; sel = 2'd3; m_rnd = 0; m_op = 0; end
         default:  begin m_sel = 0; m_rnd = 0; m_op = 0; end
      endcase
      e = {err, srdy, vld, last, stp, clr, rnd, opo, sel, we, dn, kl};
      m = {6'b111111, {4{m_rnd}}, m_op, {2{m_sel}}, 5'b11111};
   endfunction

   task automatic expect_ph(input string name, input int kind, input int k, input bit rdy,
                            input bit op, input int nr, input bit err);
      logic [17:0] e, m;
      model(kind, k, rdy, op, nr, err, kl_model, e, m);
      n_chk++;
      if ((act & m) !== (e & m)) begin
         n_fail++;
         $display("FAIL %s: outputs got %h want %h (mask %h) at %0t", name, act, e, m, $time);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic run(input vec_t v, input string tag);
      int kinds[$];
      int ks[$];
      int nr, steps, dones, guard, kind, k, want_steps;
      bit valid, rdy, hit, ab;
      nr    = nr_of(v.kl);
      valid = $onehot(v.kl);
      hit   = CacheEn && valid && v.op && dec_cached && (v.kl == kl_model);
      @(negedge clk_i);
      start_i = 1; op_i = v.op; key_len_i = v.kl; abort_i = 0;
      rk_ready_i = 1'($urandom_range(1));
      #1 expect_ph({tag, ":accept"}, PH_IDLE, 0, 0, 0, nr, 0);
      if (!valid) begin
         @(negedge clk_i);
         start_i = 0;
         #1 expect_ph({tag, ":err_pulse"}, PH_IDLE, 0, 0, 0, nr, 1);
         @(negedge clk_i);
         #1 expect_ph({tag, ":err_clear"}, PH_IDLE, 0, 0, 0, nr, 0);
         return;
      end
      if (v.kl != kl_model) dec_cached = 0;
      kl_model = v.kl;
      if (!hit) begin
         kinds.push_back(PH_INIT); ks.push_back(0);
         if (v.op) for (int i = 0; i < nr; i++) begin kinds.push_back(PH_PREP); ks.push_back(i); end
      end
      if (v.op) begin kinds.push_back(PH_LOAD); ks.push_back(0); end
      for (int i = 0; i <= nr; i++) begin kinds.push_back(PH_ROUND); ks.push_back(i); end
      steps = 0; dones = 0; guard = 0;
      while ((kinds.size() > 0) && (guard < 400)) begin
         guard++;
         @(negedge clk_i);
         start_i = 0;
         op_i = 1'($urandom_range(1));
         key_len_i = 3'($urandom_range(7));
         rdy = ($urandom_range(99) < v.pct);
         rk_ready_i = rdy;
         kind = kinds[0];
         k = ks[0];
         ab = (kind == PH_ROUND) && (k == v.abort_k);
         abort_i = ab;
         #1;
         steps += int'(step_o);
         dones += int'(done_o);
         if (ab) begin
            expect_ph({tag, ":abort"}, PH_ABORT, k, rdy, v.op, nr, 0);
            kinds.delete(); ks.delete();
            kinds.push_back(PH_WIPE); ks.push_back(0);
            dec_cached = 0;
         end else begin
            expect_ph(tag, kind, k, rdy, v.op, nr, 0);
            if (CacheEn && (kind == PH_LOAD)) dec_cached = 1;
            if ((kind != PH_ROUND) || rdy) begin kinds.pop_front(); ks.pop_front(); end
         end
      end
      if (guard >= 400) begin
         n_chk++; n_fail++;
         $display("FAIL %s:timeout got %0d cycles want < 400", tag, guard);
      end
      @(negedge clk_i);
      abort_i = 0; rk_ready_i = 0;
      #1 expect_ph({tag, ":idle_after"}, PH_IDLE, 0, 0, 0, nr, 0);
      want_steps = hit ? ((v.abort_k >= 0) ? v.abort_k : nr) : v.exp_steps;
      check_int({tag, ":steps"}, steps, want_steps);
      check_int({tag, ":done"}, dones, v.exp_done);
   endtask

   initial begin
      vec_t tbl[11];
      vec_t r;
      int sel, rnr;
      tbl[0]  = '{1'b0, 3'b001, 100, -1, 10, 1};
      tbl[1]  = '{1'b1, 3'b100, 100, -1, 28, 1};
      tbl[2]  = '{1'b0, 3'b100,  40, -1, 14, 1};
      tbl[3]  = '{1'b1, 3'b010,  50, -1, 24, 1};
      tbl[4]  = '{1'b0, 3'b010, 100, -1, 12, 1};
      tbl[5]  = '{1'b1, 3'b001,  30, -1, 20, 1};
      tbl[6]  = '{1'b0, 3'b011, 100, -1,  0, 0};
      tbl[7]  = '{1'b1, 3'b000, 100, -1,  0, 0};
      tbl[8]  = '{1'b0, 3'b001, 100,  5,  5, 0};
      tbl[9]  = '{1'b1, 3'b100,  60,  3, 17, 0};
      tbl[10] = '{1'b0, 3'b111, 100, -1,  0, 0};

      repeat (2) @(negedge clk_i);
      #1 expect_ph("reset_state", PH_IDLE, 0, 0, 0, 10, 0);
      @(negedge clk_i);
      rst_i = 0;
      #1 expect_ph("reset_release", PH_IDLE, 0, 0, 0, 10, 0);

      for (int i = 0; i < 11; i++) run(tbl[i], $sformatf("tbl%0d", i));

      // abort while idle goes through one WIPE cycle
      @(negedge clk_i);
      abort_i = 1; rk_ready_i = 0;
      @(negedge clk_i);
      abort_i = 0;
      dec_cached = 0;
      #1 expect_ph("idle_abort_wipe", PH_WIPE, 0, 0, 0, 10, 0);
      @(negedge clk_i);
      #1 expect_ph("idle_abort_back", PH_IDLE, 0, 0, 0, 10, 0);

      // reset in the middle of a decryption pre-expansion
      @(negedge clk_i);
      start_i = 1; op_i = 1; key_len_i = 3'b100; rk_ready_i = 1;
      @(negedge clk_i);
      start_i = 0;
      repeat (4) @(negedge clk_i);
      rst_i = 1;
      kl_model = 3'b001;
      dec_cached = 0;
      #1 expect_ph("rst_midrun", PH_IDLE, 0, 0, 0, 10, 0);
      @(negedge clk_i);
      rst_i = 0;
      #1 expect_ph("rst_midrun_release", PH_IDLE, 0, 0, 0, 10, 0);
      run(tbl[0], "after_rst");

`ifdef AES_KEY_SCHED_DEC_CACHE_EN
      r = '{1'b1, 3'b010, 100, -1, 24, 1};
      run(r, "cache_fill");
      run(r, "cache_hit");
      @(negedge clk_i);
      key_new_i = 1;
      @(negedge clk_i);
      key_new_i = 0;
      dec_cached = 0;
      run(r, "cache_inval");
`endif

      for (int i = 0; i < 16; i++) begin
         sel = int'($urandom_range(7));
         r.op = 1'($urandom_range(1));
         if (sel < 6) r.kl = 3'(1 << (sel % 3));
         else r.kl = 3'($urandom_range(7));
         r.pct = int'($urandom_range(100, 20));
         rnr = nr_of(r.kl);
         r.abort_k = ($urandom_range(3) == 0) ? int'($urandom_range(rnr)) : -1;
         if (!$onehot(r.kl)) begin
            r.exp_steps = 0; r.exp_done = 0;
         end else begin
            r.exp_steps = (r.op ? rnr : 0) + ((r.abort_k >= 0) ? r.abort_k : rnr);
            r.exp_done = (r.abort_k < 0) ? 1 : 0;
         end
         run(r, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
